ddr2_dfi_rd_capture: RTL and testbench
======================================

Name: ddr2_dfi_rd_capture

Overview:
- Read-data return path of the DDR2 controller, facing the PHY read side of DFI.
- When the scheduler issues a READ, the block tracks it and asserts dfi_rddata_en after the programmed read latency for BURST_BEATS cycles.
- It captures dfi_rddata/dfi_rddata_valid from the PHY, tags each beat with the AXI ID and last flag, and buffers beats for an AXI-R-style consumer.
- It throttles READ issue so a return beat never has nowhere to go, because DRAM reads cannot be stalled.

Parameters:
ID_WIDTH, `AXI_ID_WIDTH, width of the transaction ID
DATA_WIDTH, 64, DFI read data width
BURST_BEATS, 2, DFI beats returned per READ command
FIFO_DEPTH, 16, data buffer entries (power of 2, >= BURST_BEATS)
CMD_Q_DEPTH, 8, outstanding READ commands tracked (power of 2)
LAT_WIDTH, 4, width of cfg_rd_lat

Ports:
clk  in  1  controller clock
rst_n  in  1  async active-low reset
cfg_rd_lat  in  LAT_WIDTH  READ-accept to dfi_rddata_en delay in cycles; static while reads are outstanding
cmd_valid  in  1  scheduler is issuing a READ this cycle
cmd_id  in  ID_WIDTH  AXI ID of the READ
cmd_last  in  1  READ is the final command of its AXI burst
cmd_ready  out  1  READ may be issued this cycle
dfi_rddata_en  out  1  DFI read-data enable to PHY
dfi_rddata  in  DATA_WIDTH  read data from PHY
dfi_rddata_valid  in  1  read data beat valid
r_valid  out  1  beat available
r_ready  in  1  consumer accepts beat
r_id  out  ID_WIDTH  beat ID
r_data  out  DATA_WIDTH  beat data
r_last  out  1  final beat of the AXI burst
err_unexpected  out  1  sticky: valid beat with no outstanding READ, or push into a full buffer

Behaviour:
- Reset (async assert, sync release): cmd_ready=0 during reset and 1 the cycle after release. All other outputs are 0. Queues are empty, latency shift vector clear, reservation count 0. Reset mid-operation discards all in-flight state and data.
- Accept: a command is accepted on cmd_valid & cmd_ready. {cmd_id, cmd_last} are pushed into the command queue. The reservation count increases by BURST_BEATS.
- cmd_ready = (command queue not full) & (FIFO_DEPTH − fifo_count − reserved >= BURST_BEATS).
  - This is combinational from registered state only; it does not depend on cmd_valid.
- Enable timing:
  - An accept in cycle T sets bits so that dfi_rddata_en=1 in cycles T+L .. T+L+BURST_BEATS−1, where L = max(cfg_rd_lat, 1).
  - This is implemented as a 2^LAT_WIDTH+BURST_BEATS shift vector. New bits are OR-ed in, so overlapping or back-to-back windows merge. dfi_rddata_en is registered.
- Capture: each cycle with dfi_rddata_valid=1 and the command queue non-empty:
  - The beat is pushed into the data FIFO as {head.id, dfi_rddata, head.last & (beat_cnt==BURST_BEATS−1)}.
  - beat_cnt increments. reserved decrements by 1.
  - When beat_cnt==BURST_BEATS−1, beat_cnt wraps to 0 and the command queue head pops.
- Unexpected beat: dfi_rddata_valid=1 with the command queue empty drops the data and sets err_unexpected.
  - A push into a full FIFO cannot occur by construction. If it does occur, the beat is dropped and err_unexpected is set.
  - err_unexpected clears only on reset.
- Simultaneous events: accept and capture in the same cycle apply net updates to the reservation count and the queues.
  - An accept into the last free command slot in the same cycle as a head pop is legal.
  - cmd_ready uses the pre-update state.
- Output:
  - The FIFO read side is registered. A beat written in cycle C drives r_valid no earlier than C+1.
  - r_valid = FIFO not empty. r_id, r_data and r_last reflect the head entry.
  - The beat is popped on r_valid & r_ready. Outputs hold stable while r_valid & !r_ready.
  - Full-throughput: push and pop in the same cycle are both legal, including at full and at empty.
- Ordering: beats leave strictly in command-accept order. No ID reordering.
- The PHY returns exactly BURST_BEATS valid beats per READ in issue order. This block does not check the return latency.

Test Plan:
- Single read: cfg_rd_lat=5, BURST_BEATS=2, accept id=3 last=1 at cycle 10 -> dfi_rddata_en=1 in cycles 15–16 only. PHY returns 0xA at 17 and 0xB at 18, r_ready=1 -> r beat 0xA (id 3, last 0) at 18, then 0xB (id 3, last 1) at 19.
- Back-to-back: accept id=1 at cycle 10 and id=2 at cycle 12, cfg_rd_lat=4 -> dfi_rddata_en continuously high in cycles 14–17. Output order is id1, id1, id2, id2.
- Multi-command burst: id=7, cmd_last=0 then cmd_last=1 -> four beats with id 7 and r_last=1 only on the 4th.
- Backpressure: r_ready=0, FIFO_DEPTH=16, issue continuously -> cmd_ready falls after the 8th accept. After all 16 beats are stored and one pop of 2 beats, cmd_ready returns to 1. No data lost, err_unexpected=0.
- Stray beat: dfi_rddata_valid=1 with nothing outstanding -> err_unexpected=1 next cycle and stays 1, r_valid stays 0.
- Reset mid-burst: assert rst_n=0 between beats 1 and 2 -> all outputs 0 immediately. After release, a new read (id=5) completes normally with correct timing and no leftover beats.

Source files
------------

// File: rtl/ddr2_dfi_rd_capture.sv
// DDR2 DFI read-data return path: READ tracking, rddata_en generation,
// beat capture with ID/last tagging and an output buffer for an R-style consumer.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

module ddr2_dfi_rd_capture #(
  parameter int unsigned ID_WIDTH    = `AXI_ID_WIDTH,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned BURST_BEATS = 2,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned CMD_Q_DEPTH = 8,
  parameter int unsigned LAT_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LAT_WIDTH-1:0]  cfg_rd_lat,
  input  logic                  cmd_valid,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic                  cmd_last,
  output logic                  cmd_ready,
  output logic                  dfi_rddata_en,
  input  logic [DATA_WIDTH-1:0] dfi_rddata,
  input  logic                  dfi_rddata_valid,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [ID_WIDTH-1:0]   r_id,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_last,
  output logic                  err_unexpected
);

  localparam int unsigned FA_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FC_W  = FA_W + 1;
  localparam int unsigned SUM_W = FC_W + 1;
  localparam int unsigned CA_W  = (CMD_Q_DEPTH > 1) ? $clog2(CMD_Q_DEPTH) : 1;
  localparam int unsigned CC_W  = CA_W + 1;
  localparam int unsigned BC_W  = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam int unsigned SV_W  = (1 << LAT_WIDTH) + BURST_BEATS;
  localparam int unsigned CE_W  = ID_WIDTH + 1;
  localparam int unsigned FE_W  = ID_WIDTH + DATA_WIDTH + 1;

  logic [CE_W-1:0]      cq_mem [CMD_Q_DEPTH];
  logic [FE_W-1:0]      f_mem  [FIFO_DEPTH];

  logic [CA_W-1:0]      cq_wr_q, cq_wr_d, cq_rd_q, cq_rd_d;
  logic [CC_W-1:0]      cq_cnt_q, cq_cnt_d;
  logic [FA_W-1:0]      f_wr_q, f_wr_d, f_rd_q, f_rd_d;
  logic [FC_W-1:0]      f_cnt_q, f_cnt_d;
  logic [FC_W-1:0]      rsv_q, rsv_d;
  logic [BC_W-1:0]      beat_q, beat_d;
  logic [SV_W-1:0]      sv_q, sv_d;
  logic                 en_q, en_d;
  logic                 err_q, err_d;
  logic                 init_q;

  logic                 accept, cap, stray, overflow, last_beat, cq_pop;
  logic                 f_push, r_pop, f_full, cq_full, cq_empty, space_ok;
  logic [SUM_W-1:0]     used;
  logic [LAT_WIDTH-1:0] lat_eff;
  logic [SV_W-1:0]      win;
  logic [CE_W-1:0]      cq_head;
  logic [FE_W-1:0]      f_wdata, f_head;

  // Issue throttle: only from registered state, never from cmd_valid
  assign cq_full   = (cq_cnt_q == CC_W'(CMD_Q_DEPTH));
  assign cq_empty  = (cq_cnt_q == '0);
  assign used      = SUM_W'(f_cnt_q) + SUM_W'(rsv_q);
  assign space_ok  = (used + SUM_W'(BURST_BEATS)) <= SUM_W'(FIFO_DEPTH);
  assign cmd_ready = init_q & ~cq_full & space_ok;

  assign accept    = cmd_valid & cmd_ready;
  assign cap       = dfi_rddata_valid & ~cq_empty;
  assign stray     = dfi_rddata_valid & cq_empty;
  assign last_beat = (beat_q == BC_W'(BURST_BEATS - 1));
  assign cq_pop    = cap & last_beat;

  assign r_valid   = (f_cnt_q != '0);
  assign r_pop     = r_valid & r_ready;
  assign f_full    = (f_cnt_q == FC_W'(FIFO_DEPTH));
  assign f_push    = cap & (~f_full | r_pop);
  assign overflow  = cap & f_full & ~r_pop;

  assign cq_head   = cq_mem[cq_rd_q];
  assign f_wdata   = {cq_head[CE_W-1:1], dfi_rddata, cq_head[0] & last_beat};
  assign f_head    = f_mem[f_rd_q];

  // Enable window: a latency of 0 behaves as 1
  assign lat_eff   = (cfg_rd_lat == '0) ? LAT_WIDTH'(1) : cfg_rd_lat;
  assign win       = SV_W'({BURST_BEATS{1'b1}}) << (lat_eff - LAT_WIDTH'(1));

  // Outputs forced to zero while the buffer is empty (including in reset)
  assign r_id           = r_valid ? f_head[FE_W-1 -: ID_WIDTH] : '0;
  assign r_data         = r_valid ? f_head[DATA_WIDTH:1] : '0;
  assign r_last         = r_valid & f_head[0];
  assign dfi_rddata_en  = en_q;
  assign err_unexpected = err_q;

  // Next-state for queues, counters, latency vector and error flag
  always_comb begin
    cq_wr_d  = cq_wr_q;
    cq_rd_d  = cq_rd_q;
    cq_cnt_d = cq_cnt_q;
    f_wr_d   = f_wr_q;
    f_rd_d   = f_rd_q;
    f_cnt_d  = f_cnt_q;
    rsv_d    = rsv_q;
    beat_d   = beat_q;
    sv_d     = sv_q >> 1;
    err_d    = err_q | stray | overflow;

    if (accept) begin
      cq_wr_d = cq_wr_q + CA_W'(1);
      rsv_d   = rsv_d + FC_W'(BURST_BEATS);
      sv_d    = sv_d | win;
    end
    if (cap) begin
      beat_d = last_beat ? '0 : beat_q + BC_W'(1);
      if (rsv_d != '0) rsv_d = rsv_d - FC_W'(1);
    end
    if (cq_pop) cq_rd_d = cq_rd_q + CA_W'(1);
    cq_cnt_d = cq_cnt_q + CC_W'(accept) - CC_W'(cq_pop);

    if (f_push) f_wr_d = f_wr_q + FA_W'(1);
    if (r_pop)  f_rd_d = f_rd_q + FA_W'(1);
    f_cnt_d = f_cnt_q + FC_W'(f_push) - FC_W'(r_pop);

    en_d = sv_d[0];
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cq_wr_q  <= '0;
      cq_rd_q  <= '0;
      cq_cnt_q <= '0;
      f_wr_q   <= '0;
      f_rd_q   <= '0;
      f_cnt_q  <= '0;
      rsv_q    <= '0;
      beat_q   <= '0;
      sv_q     <= '0;
      en_q     <= 1'b0;
      err_q    <= 1'b0;
      init_q   <= 1'b0;
    end else begin
      cq_wr_q  <= cq_wr_d;
      cq_rd_q  <= cq_rd_d;
      cq_cnt_q <= cq_cnt_d;
      f_wr_q   <= f_wr_d;
      f_rd_q   <= f_rd_d;
      f_cnt_q  <= f_cnt_d;
      rsv_q    <= rsv_d;
      beat_q   <= beat_d;
      sv_q     <= sv_d;
      en_q     <= en_d;
      err_q    <= err_d;
      init_q   <= 1'b1;
    end
  end

  // Storage arrays; validity is tracked by the pointers and counts above
  always_ff @(posedge clk) begin
    if (accept) cq_mem[cq_wr_q] <= {cmd_id, cmd_last};
    if (f_push) f_mem[f_wr_q]   <= f_wdata;
  end

endmodule

// File: tb/tb_ddr2_dfi_rd_capture.sv
// Directed self-checking bench for ddr2_dfi_rd_capture.
module tb_ddr2_dfi_rd_capture;

  localparam int unsigned IDW = 4;
  localparam int unsigned DW  = 64;
  localparam int unsigned LW  = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [LW-1:0]  cfg_rd_lat = '0;
  logic           cmd_valid = 1'b0;
  logic [IDW-1:0] cmd_id = '0;
  logic           cmd_last = 1'b0;
  logic           cmd_ready;
  logic           dfi_rddata_en;
  logic [DW-1:0]  dfi_rddata = '0;
  logic           dfi_rddata_valid = 1'b0;
  logic           r_valid;
  logic           r_ready = 1'b0;
  logic [IDW-1:0] r_id;
  logic [DW-1:0]  r_data;
  logic           r_last;
  logic           err_unexpected;

  int n_chk = 0;
  int n_err = 0;
  int n_acc;

  always #5 clk = ~clk;

  ddr2_dfi_rd_capture #(
    .ID_WIDTH(IDW), .DATA_WIDTH(DW), .BURST_BEATS(2),
    .FIFO_DEPTH(16), .CMD_Q_DEPTH(8), .LAT_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_rd_lat(cfg_rd_lat),
    .cmd_valid(cmd_valid), .cmd_id(cmd_id), .cmd_last(cmd_last), .cmd_ready(cmd_ready),
    .dfi_rddata_en(dfi_rddata_en), .dfi_rddata(dfi_rddata), .dfi_rddata_valid(dfi_rddata_valid),
    .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data), .r_last(r_last),
    .err_unexpected(err_unexpected)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next active edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rv"}, 64'(r_valid), 0);
    chk({tag, "_en"}, 64'(dfi_rddata_en), 0);
    chk({tag, "_err"}, 64'(err_unexpected), 0);
    chk({tag, "_rd"}, r_data, 0);
    chk({tag, "_ri"}, 64'(r_id), 0);
    chk({tag, "_rl"}, 64'(r_last), 0);
  endtask

  initial begin
    // Reset behaviour
    #2;
    chk("rst_rdy", 64'(cmd_ready), 0);
    chk_idle("rst");
    cyc(); cyc();
    rst_n = 1'b1;
    chk("rel_rdy0", 64'(cmd_ready), 0);
    cyc();
    chk("rel_rdy1", 64'(cmd_ready), 1);

    // Single read, latency 5
    cfg_rd_lat = 4'd5; r_ready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      chk("t1_en", 64'(dfi_rddata_en), 64'(k == 5 || k == 6));
      chk("t1_rv", 64'(r_valid), 64'(k == 8 || k == 9));
      if (k == 8 || k == 9) begin
        chk("t1_rd", r_data, 64'(k + 2));
        chk("t1_ri", 64'(r_id), 3);
        chk("t1_rl", 64'(r_last), 64'(k == 9));
      end
      cmd_valid = (k == 0); cmd_id = 4'd3; cmd_last = 1'b1;
      dfi_rddata_valid = (k == 7 || k == 8);
      dfi_rddata = 64'(k + 3);
      cyc();
    end
    dfi_rddata_valid = 1'b0;

    // Back-to-back reads, latency 4: windows merge
    cfg_rd_lat = 4'd4;
    for (int k = 0; k <= 13; k++) begin
      chk("t2_en", 64'(dfi_rddata_en), 64'(k >= 4 && k <= 7));
      chk("t2_rv", 64'(r_valid), 64'(k >= 9 && k <= 12));
      if (k >= 9 && k <= 12) begin
        chk("t2_rd", r_data, 64'h100 + 64'(k - 1));
        chk("t2_ri", 64'(r_id), (k <= 10) ? 1 : 2);
        chk("t2_rl", 64'(r_last), 64'(k == 10 || k == 12));
      end
      cmd_valid = (k == 0 || k == 2); cmd_id = (k == 0) ? 4'd1 : 4'd2; cmd_last = 1'b1;
      dfi_rddata_valid = (k >= 8 && k <= 11);
      dfi_rddata = 64'h100 + 64'(k);
      cyc();
    end
    dfi_rddata_valid = 1'b0;

    // Two commands of one AXI burst, latency 3
    cfg_rd_lat = 4'd3;
    for (int k = 0; k <= 11; k++) begin
      chk("t3_en", 64'(dfi_rddata_en), 64'(k >= 3 && k <= 5));
      chk("t3_rv", 64'(r_valid), 64'(k >= 7 && k <= 10));
      if (k >= 7 && k <= 10) begin
        chk("t3_rd", r_data, 64'h70 + 64'(k - 7));
        chk("t3_ri", 64'(r_id), 7);
        chk("t3_rl", 64'(r_last), 64'(k == 10));
      end
      cmd_valid = (k == 0 || k == 1); cmd_id = 4'd7; cmd_last = (k == 1);
      dfi_rddata_valid = (k >= 6 && k <= 9);
      dfi_rddata = 64'h70 + 64'(k - 6);
      cyc();
    end
    dfi_rddata_valid = 1'b0;

    // Backpressure: reservations stop issue at 8 commands
    r_ready = 1'b0; cfg_rd_lat = 4'd1; n_acc = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 8) chk("t4_rdy_low", 64'(cmd_ready), 0);
      cmd_valid = 1'b1; cmd_id = IDW'(n_acc); cmd_last = 1'b1;
      if (cmd_ready) n_acc++;
      cyc();
    end
    cmd_valid = 1'b0;
    chk("t4_acc", 64'(n_acc), 8);
    for (int i = 0; i < 16; i++) begin
      chk("t4_rdy_fill", 64'(cmd_ready), 0);
      dfi_rddata_valid = 1'b1; dfi_rddata = 64'h4000 + 64'(i);
      cyc();
    end
    dfi_rddata_valid = 1'b0;
    chk("t4_rdy_full", 64'(cmd_ready), 0);
    chk("t4_rv_full", 64'(r_valid), 1);
    r_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("t4_pop_rd", r_data, 64'h4000 + 64'(i));
      cyc();
    end
    r_ready = 1'b0;
    chk("t4_rdy_back", 64'(cmd_ready), 1);
    r_ready = 1'b1;
    for (int i = 2; i < 16; i++) begin
      chk("t4_drain_rv", 64'(r_valid), 1);
      chk("t4_drain_rd", r_data, 64'h4000 + 64'(i));
      chk("t4_drain_ri", 64'(r_id), 64'(i / 2));
      chk("t4_drain_rl", 64'(r_last), 64'(i % 2));
      cyc();
    end
    chk("t4_empty", 64'(r_valid), 0);
    chk("t4_err", 64'(err_unexpected), 0);

    // Stray beat with nothing outstanding
    dfi_rddata_valid = 1'b1; dfi_rddata = 64'hDEAD;
    chk("t5_err_pre", 64'(err_unexpected), 0);
    cyc();
    dfi_rddata_valid = 1'b0;
    chk("t5_err", 64'(err_unexpected), 1);
    chk("t5_rv", 64'(r_valid), 0);
    cyc(); cyc(); cyc();
    chk("t5_err_hold", 64'(err_unexpected), 1);
    chk("t5_rv_hold", 64'(r_valid), 0);

    // Reset between beat 1 and beat 2
    cfg_rd_lat = 4'd4; r_ready = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      cmd_valid = (k == 0); cmd_id = 4'd9; cmd_last = 1'b1;
      dfi_rddata_valid = (k == 4); dfi_rddata = 64'h91;
      cyc();
    end
    cmd_valid = 1'b0; dfi_rddata_valid = 1'b0;
    chk("t6_en_pre", 64'(dfi_rddata_en), 1);
    chk("t6_rv_pre", 64'(r_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rdy_rst", 64'(cmd_ready), 0);
    chk_idle("t6_rst");
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    chk("t6_rdy_rel", 64'(cmd_ready), 1);
    chk("t6_err_clr", 64'(err_unexpected), 0);
    r_ready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      chk("t6_en", 64'(dfi_rddata_en), 64'(k == 4 || k == 5));
      chk("t6_rv", 64'(r_valid), 64'(k == 7 || k == 8));
      if (k == 7 || k == 8) begin
        chk("t6_rd", r_data, 64'h50 + 64'(k - 7));
        chk("t6_ri", 64'(r_id), 5);
        chk("t6_rl", 64'(r_last), 64'(k == 8));
      end
      cmd_valid = (k == 0); cmd_id = 4'd5; cmd_last = 1'b1;
      dfi_rddata_valid = (k == 6 || k == 7);
      dfi_rddata = 64'h50 + 64'(k - 6);
      cyc();
    end
    dfi_rddata_valid = 1'b0;
    chk("t6_err_end", 64'(err_unexpected), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
